// File: rtl/hll_sketch_streamer.sv
// ---------------------------------------------------------------------------
// hll_sketch_streamer
//
// HyperLogLog sketch builder. Incoming 64-bit hashes update a bank of
// 16384 4-bit max-rho registers, packed 32 per 128-bit RAM word
// (512 words). A flush drains the update pipeline and then streams the
// whole sketch out as 512 beats, clearing each word as it is read.
//
// Optional build macro:
//   HLL_STREAM_PRESERVE_EN - when defined, streaming does not clear the
//                            sketch, so successive flushes report a
//                            running union. Reset still clears the RAM.
//
// Ports:
//   clk       in   clock, all logic on the rising edge
//   rst       in   synchronous active-high reset
//   in_hash   in   hash; low 14 bits index the register, the rest give rho
//   in_valid  in   in_hash is valid
//   in_ready  out  hash or flush accepted this cycle
//   flush     in   single-cycle request to emit and clear the sketch
//   data      out  sketch beat; lane k in data[4k+3:4k], zero when idle
//   valid     out  data is valid
//   out_last  out  high with the final beat
// ---------------------------------------------------------------------------
module hll_sketch_streamer #(
   parameter int HASH_W     = 64,
   parameter int WORDS_LOG2 = 9,
   parameter int LANES      = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [HASH_W-1:0]    in_hash,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 flush,
   output logic [LANES*4-1:0]   data,
   output logic                 valid,
   output logic                 out_last
);

   localparam int LANE_BITS = $clog2(LANES);
   localparam int IDX_W     = WORDS_LOG2 + LANE_BITS;
   localparam int DATA_W    = LANES * 4;
   localparam int DEPTH     = 1 << WORDS_LOG2;
   localparam int FIELD_W   = HASH_W - IDX_W;
   localparam int CLZ_W     = $clog2(FIELD_W + 1);
   localparam int CNT_W     = WORDS_LOG2 + 1;

   typedef enum logic [1:0] {
      INIT_CLEAR = 2'd0,
      ACCUM      = 2'd1,
      DRAIN      = 2'd2,
      STREAM     = 2'd3
   } state_t;

   state_t                  state_reg, state_next;
   logic [CNT_W-1:0]        cnt_reg, cnt_next;

   // Sketch RAM: one write port, one registered read port.
   logic [DATA_W-1:0]       mem [DEPTH];
   logic [WORDS_LOG2-1:0]   rd_addr;
   logic [DATA_W-1:0]       rd_q_reg;
   logic                    wr_en;
   logic [WORDS_LOG2-1:0]   wr_addr;
   logic [DATA_W-1:0]       wr_data;

   // Stage S0 decode (combinational from the input hash).
   logic [WORDS_LOG2-1:0]   s0_word;
   logic [LANE_BITS-1:0]    s0_lane;
   logic [3:0]              s0_rho;
   logic [CLZ_W-1:0]        clz;

   // Stage S1 registers.
   logic                    s1_valid_reg;
   logic [WORDS_LOG2-1:0]   s1_word_reg;
   logic [LANE_BITS-1:0]    s1_lane_reg;
   logic [3:0]              s1_rho_reg;
   logic                    fwd_hit_reg;
   logic [DATA_W-1:0]       fwd_data_reg;
   logic [DATA_W-1:0]       s1_old;
   logic [DATA_W-1:0]       s1_new;

   logic                    accept_hash;
   logic                    stream_rd;
   logic                    valid_reg;
   logic                    last_reg;

   assign s0_word = in_hash[IDX_W-1:LANE_BITS];
   assign s0_lane = in_hash[LANE_BITS-1:0];

   // Leading-zero count of the rho field. Scanning upward lets the highest
   // set bit win; an all-zero field keeps the full field width.
   always_comb begin
      clz = CLZ_W'(FIELD_W);
      for (int i = 0; i < FIELD_W; i++) begin
         if (in_hash[IDX_W + i]) begin
            clz = CLZ_W'(FIELD_W - 1 - i);
         end
      end
      s0_rho = (clz >= CLZ_W'(14)) ? 4'hF : 4'(clz + CLZ_W'(1));
   end

   // ---------------- control FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= INIT_CLEAR;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      in_ready   = 1'b0;
      stream_rd  = 1'b0;
      case (state_reg)
         INIT_CLEAR: begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(DEPTH - 1)) begin
               state_next = ACCUM;
               cnt_next   = '0;
            end
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (flush) begin
               state_next = DRAIN;
               cnt_next   = '0;
            end
         end
         DRAIN: begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
               state_next = STREAM;
               cnt_next   = '0;
            end
         end
         STREAM: begin
            // cnt 0..DEPTH-1 issue reads; cnt == DEPTH is a spare cycle
            // while the final beat leaves, so in_ready returns after it.
            if (!cnt_reg[WORDS_LOG2]) begin
               stream_rd = 1'b1;
               cnt_next  = cnt_reg + CNT_W'(1);
            end else begin
               state_next = ACCUM;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = INIT_CLEAR;
            cnt_next   = '0;
         end
      endcase
   end

   assign accept_hash = in_valid & in_ready;

   // ---------------- RAM ports ----------------
   assign rd_addr = (state_reg == STREAM) ? cnt_reg[WORDS_LOG2-1:0] : s0_word;

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = s1_word_reg;
      wr_data = s1_new;
      if (state_reg == INIT_CLEAR) begin
         wr_en   = 1'b1;
         wr_addr = cnt_reg[WORDS_LOG2-1:0];
         wr_data = '0;
      end else if (stream_rd) begin
`ifndef HLL_STREAM_PRESERVE_EN
         // Read-first RAM: the word leaves on the read port and is
         // cleared in the same cycle.
         wr_en   = 1'b1;
         wr_addr = cnt_reg[WORDS_LOG2-1:0];
         wr_data = '0;
`endif
      end else if (s1_valid_reg) begin
         wr_en = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_q_reg <= mem[rd_addr];
   end

   // ---------------- update pipeline ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
         fwd_hit_reg  <= 1'b0;
         valid_reg    <= 1'b0;
         last_reg     <= 1'b0;
      end else begin
         s1_valid_reg <= accept_hash;
         // The RAM read for this S0 word misses the write S1 is doing now,
         // so remember to take S1's data instead.
         fwd_hit_reg  <= s1_valid_reg && (s1_word_reg == s0_word);
         valid_reg    <= stream_rd;
         last_reg     <= stream_rd && (cnt_reg == CNT_W'(DEPTH - 1));
      end
   end

   always_ff @(posedge clk) begin
      s1_word_reg  <= s0_word;
      s1_lane_reg  <= s0_lane;
      s1_rho_reg   <= s0_rho;
      fwd_data_reg <= s1_new;
   end

   assign s1_old = fwd_hit_reg ? fwd_data_reg : rd_q_reg;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic [3:0] old_lane;
         assign old_lane = s1_old[4*gi +: 4];
         assign s1_new[4*gi +: 4] =
            ((s1_lane_reg == LANE_BITS'(gi)) && (s1_rho_reg > old_lane)) ? s1_rho_reg : old_lane;
      end
   endgenerate

   // ---------------- outputs ----------------
   assign valid    = valid_reg;
   assign out_last = last_reg;
   assign data     = valid_reg ? rd_q_reg : '0;

endmodule

// File: tb/tb_hll_sketch_streamer.sv
module tb_hll_sketch_streamer;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [63:0]   in_hash = '0;
   logic          in_valid = 1'b0;
   logic          flush = 1'b0;
   logic          in_ready;
   logic [127:0]  data;
   logic          valid;
   logic          out_last;

   int n_vec = 0;
   int n_err = 0;

   logic [3:0]    model [16384];
   logic [127:0]  beats [512];
   logic [127:0]  prev_beats [512];

   hll_sketch_streamer dut (
      .clk      (clk),
      .rst      (rst),
      .in_hash  (in_hash),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .flush    (flush),
      .data     (data),
      .valid    (valid),
      .out_last (out_last)
   );

   always #5 clk = ~clk;

   // rho = 1 + leading zeros of bits [63:14], capped at 15
   function automatic int rho_of(input logic [63:0] h);
      int z = 0;
      for (int b = 63; b >= 14; b--) begin
         if (h[b]) break;
         z++;
      end
      if (z + 1 > 15) return 15;
      return z + 1;
   endfunction

   function automatic logic [127:0] exp_beat(input int n);
      logic [127:0] b;
      for (int l = 0; l < 32; l++) b[4*l +: 4] = model[n*32 + l];
      return b;
   endfunction

   task automatic model_clear();
      foreach (model[i]) model[i] = 4'd0;
   endtask

   task automatic drive_cycle(input logic v, input logic [63:0] h, input logic f, output logic rdy);
      int idx;
      int r;
      @(negedge clk);
      in_valid = v;
      in_hash  = h;
      flush    = f;
      rdy      = in_ready;
      if (v && rdy) begin
         idx = int'(h[13:0]);
         r   = rho_of(h);
         if (r > int'(model[idx])) model[idx] = 4'(r);
      end
   endtask

   // Called on the negedge of the first cycle after reset is released.
   task automatic check_init_clear(input string tag);
      int bad = 0;
      for (int c = 0; c < 512; c++) begin
         if (c > 0) @(negedge clk);
         if (in_ready !== 1'b0) bad++;
      end
      n_vec++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL %s init_ready_low: %0d cycles with in_ready=1, required 0", tag, bad);
      end
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s init_ready_rise: in_ready=%b at cycle 512, required 1", tag, in_ready);
      end
   endtask

   // Flush (optionally with a hash), then check the full stream timing and beats.
   task automatic flush_and_stream(input logic v, input logic [63:0] h, input string tag);
      logic rdy;
      logic exp_v, exp_l, exp_r;
      logic [127:0] exp [512];
      drive_cycle(v, h, 1'b1, rdy);
      n_vec++;
      if (rdy !== 1'b1) begin
         n_err++;
         $display("FAIL %s flush_ready: in_ready=%b, required 1", tag, rdy);
      end
      for (int n = 0; n < 512; n++) exp[n] = exp_beat(n);
`ifndef HLL_STREAM_PRESERVE_EN
      model_clear();
`endif
      for (int k = 1; k <= 516; k++) begin
         @(negedge clk);
         // stray flush and hashes while busy must be ignored
         flush    = (k == 100);
         in_valid = (k % 7 == 3) && (k < 510);
         in_hash  = {$urandom, $urandom};
         exp_v = (k >= 4) && (k <= 515);
         exp_l = (k == 515);
         exp_r = (k == 516);
         n_vec++;
         if (valid !== exp_v || out_last !== exp_l || in_ready !== exp_r) begin
            n_err++;
            $display("FAIL %s timing T+%0d: valid/last/ready=%b%b%b, required %b%b%b",
                     tag, k, valid, out_last, in_ready, exp_v, exp_l, exp_r);
         end
         if (exp_v) begin
            beats[k-4] = data;
            n_vec++;
            if (data !== exp[k-4]) begin
               n_err++;
               $display("FAIL %s beat %0d: data=%h, required %h", tag, k-4, data, exp[k-4]);
            end
         end
      end
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   function automatic int count_nonzero_beats(input int from);
      int c = 0;
      for (int n = from; n < 512; n++) if (beats[n] !== 128'd0) c++;
      return c;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++;
      if (valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b0 || data !== 128'd0) begin
         n_err++;
         $display("FAIL reset_outputs: valid=%b last=%b ready=%b data=%h, required all 0",
                  valid, out_last, in_ready, data);
      end
      rst = 1'b0;
      check_init_clear("reset");
      model_clear();
   endtask

   task automatic test_empty_flush();
      int zc = 0;
      longint sum = 0;
      flush_and_stream(1'b0, 64'd0, "empty");
      for (int n = 0; n < 512; n++)
         for (int l = 0; l < 32; l++) begin
            if (beats[n][4*l +: 4] == 4'd0) zc++;
            sum += longint'(1) << (16 - int'(beats[n][4*l +: 4]));
         end
      n_vec++;
      if (zc != 16384) begin
         n_err++;
         $display("FAIL empty zero_count: got %0d, required 16384", zc);
      end
      n_vec++;
      if (sum != (longint'(1) << 30)) begin
         n_err++;
         $display("FAIL empty sum: got %0d, required %0d", sum, longint'(1) << 30);
      end
   endtask

   task automatic test_single();
      logic rdy;
      logic [127:0] want;
      want = 128'h0000_0000_0000_0000_0000_0000_00F0_0000;
      drive_cycle(1'b1, 64'h0000_0000_0000_0005, 1'b0, rdy);
      flush_and_stream(1'b0, 64'd0, "single");
      n_vec++;
      if (beats[0] !== want) begin
         n_err++;
         $display("FAIL single beat0: got %h, required %h", beats[0], want);
      end
      n_vec++;
      if (count_nonzero_beats(1) != 0) begin
         n_err++;
         $display("FAIL single others: %0d nonzero beats, required 0", count_nonzero_beats(1));
      end
   endtask

   task automatic test_back_to_back();
      logic r0, r1, r2;
      drive_cycle(1'b1, 64'h8000_0000_0000_0021, 1'b0, r0);
      drive_cycle(1'b1, 64'h4000_0000_0000_0021, 1'b0, r1);
      drive_cycle(1'b1, 64'h8000_0000_0000_0021, 1'b0, r2);
      n_vec++;
      if ({r0, r1, r2} !== 3'b111) begin
         n_err++;
         $display("FAIL b2b ready: got %b, required 111", {r0, r1, r2});
      end
      flush_and_stream(1'b0, 64'd0, "b2b");
      n_vec++;
      if (beats[1][7:4] !== 4'd2) begin
         n_err++;
         $display("FAIL b2b lane: beat1 lane1=%0d, required 2", beats[1][7:4]);
      end
   endtask

   task automatic test_flush_with_hash();
      flush_and_stream(1'b1, 64'h2000_0000_0000_3FFF, "flush_hash");
      n_vec++;
      if (beats[511][127:124] !== 4'd3) begin
         n_err++;
         $display("FAIL flush_hash lane: beat511 lane31=%0d, required 3", beats[511][127:124]);
      end
      for (int n = 0; n < 512; n++) prev_beats[n] = beats[n];
   endtask

   task automatic test_second_flush();
      int diffs = 0;
      flush_and_stream(1'b0, 64'd0, "second");
`ifdef HLL_STREAM_PRESERVE_EN
      for (int n = 0; n < 512; n++) if (beats[n] !== prev_beats[n]) diffs++;
`else
      diffs = count_nonzero_beats(0);
`endif
      n_vec++;
      if (diffs != 0) begin
         n_err++;
         $display("FAIL second contents: %0d beats differ, required 0", diffs);
      end
   endtask

   task automatic test_random();
      logic rdy;
      logic [63:0] hi;
      logic [13:0] idx;
      logic [8:0]  w;
      for (int round = 0; round < 3; round++) begin
         for (int i = 0; i < 200; i++) begin
            hi = {$urandom, $urandom} >> $urandom_range(0, 16);
            // a few hot words provoke back-to-back hazards
            w  = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 3)) : 9'($urandom_range(0, 511));
            idx = {w, 5'($urandom_range(0, 31))};
            drive_cycle($urandom_range(0, 3) != 0, {hi[63:14], idx}, 1'b0, rdy);
         end
         hi = {$urandom, $urandom};
         flush_and_stream(1'($urandom_range(0, 1)), hi, "random");
      end
   endtask

   task automatic test_reset_mid();
      logic rdy;
      logic [127:0] want;
      drive_cycle(1'b1, 64'h0800_0000_0000_1905, 1'b0, rdy);   // word 200 lane 5
      drive_cycle(1'b1, 64'h0000_4000_0000_1910, 1'b0, rdy);   // word 200 lane 16
      drive_cycle(1'b0, 64'd0, 1'b1, rdy);
      want = exp_beat(200);
      for (int k = 1; k <= 204; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         flush    = 1'b0;
      end
      n_vec++;
      if (valid !== 1'b1 || data !== want) begin
         n_err++;
         $display("FAIL midrst beat200: valid=%b data=%h, required 1 %h", valid, data, want);
      end
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if (valid !== 1'b0 || out_last !== 1'b0) begin
         n_err++;
         $display("FAIL midrst valid_drop: valid=%b last=%b, required 0 0", valid, out_last);
      end
      rst = 1'b0;
      check_init_clear("midrst");
      model_clear();
      flush_and_stream(1'b0, 64'd0, "after_midrst");
      n_vec++;
      if (count_nonzero_beats(0) != 0) begin
         n_err++;
         $display("FAIL after_midrst contents: %0d nonzero beats, required 0", count_nonzero_beats(0));
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_empty_flush();
      test_single();
      test_back_to_back();
      test_flush_with_hash();
      test_second_flush();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hll_sketch_streamer.md
Name: hll_sketch_streamer

Overview:
HyperLogLog sketch builder that sits upstream of the cardinality estimator in krnl_dist.
- Ingests 64-bit hashes and keeps 16384 4-bit max-rho registers in on-chip RAM.
- On flush, streams the whole sketch as 512 beats of 128 bits and clears it.
- Each beat holds 32 registers; the estimator sums these beats and counts their zeros.

Parameters:
HASH_W, 64, input hash width; bits [13:0] are the register index, bits [HASH_W-1:14] are the rho field
WORDS_LOG2, 9, log2 of beats per sketch (fixed at 9 for the 512-beat estimator)
LANES, 32, 4-bit registers per 128-bit beat

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_hash  in  HASH_W  hash value
in_valid  in  1  in_hash is valid
in_ready  out  1  block accepts a hash or flush this cycle
flush  in  1  single-cycle request to emit the sketch; taken only when in_ready=1
data  out  128  sketch beat; register lane k sits in data[4k+3:4k]
valid  out  1  data is valid (no backpressure; the estimator always accepts)
out_last  out  1  high with beat 511

Behaviour:
- Reset values: in_ready=0, valid=0, out_last=0, data=0. State goes to INIT_CLEAR.
- Index decode:
  - idx = in_hash[13:0]
  - word = idx[13:5]
  - lane = idx[4:0]
- Rho computation:
  - rho = 1 + count of leading zeros of in_hash[HASH_W-1:14], counted from the MSB.
  - Saturate at 15; an all-zero field gives 15.
  - The result is always in 1..15.
- States:
  - INIT_CLEAR: writes zero to words 0..511, one per cycle (512 cycles), in_ready=0, then goes to ACCUM.
  - ACCUM: in_ready=1. A hash is accepted when in_valid & in_ready. A flush is accepted when flush & in_ready; if in_valid is also high that cycle, the hash is included in the sketch. An accepted flush moves to DRAIN.
  - DRAIN: 2 cycles, in_ready=0. Lets the update pipeline retire its writes. Then goes to STREAM.
  - STREAM: issues reads for words 0..511 on consecutive cycles. Each word is written back as zero in the cycle its read is issued. After the last read the state returns to ACCUM.
- Update pipeline (RAM read latency 1):
  - S0: issue the read and register word, lane, rho.
  - S1: new = max(old lane, rho); write the word back.
  - Sustains 1 hash per cycle.
- Hazard: if the S0 word equals the word being written by S1, S0 uses the S1 write data instead of the RAM output. Back-to-back hits to the same word or lane must give the correct max.
- Stream timing:
  - Flush accepted in cycle T.
  - Reads issued T+3..T+514.
  - valid high T+4..T+515, contiguous, beat n = word n.
  - out_last high at T+515.
  - in_ready rises at T+516.
- Arithmetic: max is unsigned 4-bit. Registers never decrease while in ACCUM.
- Reset mid-operation (any state): valid drops the next cycle, any partial stream is abandoned, and the block re-enters INIT_CLEAR.
- flush while in_ready=0 is ignored and not queued.
- in_valid while in_ready=0: the hash is dropped; the source must hold it until ready.

Optional Feature:
HLL_STREAM_PRESERVE_EN
- Defined: STREAM does not write zeros back. The sketch persists across flushes, giving a running union. INIT_CLEAR still runs after reset.
- Undefined: each flush clears the sketch (default behaviour).

Test Plan:
- Reset then flush with no hashes:
  - in_ready=0 for 512 cycles after reset.
  - After the flush, 512 beats of data=0.
  - Downstream estimator reports sum=2^30 and zero_count=16384.
- Single hash 64'h0000_0000_0000_0005, then flush:
  - Beat 0 = 128'h0000...00F0_0000 (lane 5 = 15, rho saturated).
  - All other beats are 0.
- Hashes in consecutive cycles, all to word 1 lane 1:
  - 64'h8000_0000_0000_0021 (rho=1), then 64'h4000_0000_0000_0021 (rho=2), then 64'h8000_0000_0000_0021 (rho=1).
  - After flush, beat 1 lane 1 = 2, which checks the forwarding path.
- Flush and in_valid in the same cycle with hash 64'h2000_0000_0000_3FFF:
  - Hash is included: beat 511 lane 31 = 3.
  - valid runs exactly 512 contiguous cycles starting at T+4; out_last only at T+515.
  - A flush pulse during the stream is ignored.
- Second flush with no new hashes:
  - Without the macro: all beats are 0.
  - With HLL_STREAM_PRESERVE_EN: beats match the first stream.
- rst asserted at beat 200 of a stream:
  - valid=0 the next cycle.
  - 512-cycle INIT_CLEAR runs.
  - A following flush streams all-zero beats.
